uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 100, meaning CLOCK cycles per serial bit; legal range 2..1048575 (20-bit counter).
REQ-002 Parameter FIFO_DEPTH, default 4, meaning number of byte entries in the transmit FIFO; legal values are powers of two, 2..16.
REQ-003 Parameter PARITY_EN, default 0, meaning insert an even-parity bit after the data bits when 1; 8N1 framing when 0.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-005 CLOCK  in  1  sole clock; all state updates on its rising edge.
REQ-006 RESETN  in  1  asynchronous active-low reset.
REQ-007 dt  in  8  byte to transmit; sampled when wr=1.
REQ-008 wr  in  1  write strobe; one byte is pushed per cycle in which wr=1 and the push is accepted.
REQ-009 full  out  1  FIFO holds FIFO_DEPTH entries.
REQ-010 empty  out  1  FIFO holds 0 entries.
REQ-011 busy  out  1  serializer not in IDLE.
REQ-012 TX  out  1  serial line, idle high; registered output.

Function
REQ-013 Frame format: start bit (0), data bits d0..d7 LSB first, optional parity bit (PARITY_EN=1), one stop bit (1).
REQ-014 Each frame bit is held on TX for exactly CLKS_PER_BIT cycles.
REQ-015 Serializer FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-016 FSM transitions:
  - IDLE->START when FIFO is not empty; the FIFO pops on the same edge.
  - START->DATA after one bit time.
  - DATA->PARITY (PARITY_EN=1) or DATA->STOP (PARITY_EN=0) after the 8th bit.
  - PARITY->STOP after one bit time.
  - STOP->START when FIFO is not empty at the end of the stop bit, with a pop on that edge; otherwise STOP->IDLE.
REQ-017 Back-to-back frames have no idle gap; the stop bit is exactly CLKS_PER_BIT cycles.
REQ-018 Parity bit value: XOR of d0..d7, so that data plus parity has an even count of ones.
REQ-019 Start latency: with wr=1 sampled at edge N while the FIFO is empty and the FSM is IDLE, the byte is stored at N, popped at N+1, and TX=0 from edge N+1.
REQ-020 FIFO ordering: strict first-in first-out; the pointers wrap modulo FIFO_DEPTH; the occupancy counter is wide enough to represent FIFO_DEPTH.
REQ-021 A push while full=1 is discarded and leaves FIFO contents and pointers unchanged, even when a pop occurs on the same edge.
REQ-022 A simultaneous push and pop when the FIFO is not full both take effect, and occupancy is unchanged.
REQ-023 A pop never occurs when the FIFO is empty.
REQ-024 full and empty are registered or derived from the registered count, and are valid in the cycle after the edge that changes occupancy.
REQ-025 dt is captured into the serializer shift register at pop; later FIFO writes do not affect a frame in flight.

Reset
REQ-026 While RESETN=0, regardless of CLOCK:
  - TX=1, busy=0, empty=1, full=0
  - FSM=IDLE
  - bit counter and baud counter = 0
  - FIFO pointers and count = 0
REQ-027 Reset asserted mid-frame aborts the frame immediately (TX returns high) and discards all queued bytes.
REQ-028 After RESETN rises, no frame starts until a new push.

Verification
REQ-029 Single byte: defaults, push 0xA5 at edge N -> TX low for cycles N+1..N+100, then bits 1,0,1,0,0,1,0,1 for 100 cycles each, stop high for 100 cycles; busy=0 from edge N+1001.
REQ-030 Back-to-back: push 0x00 and 0xFF on consecutive cycles -> two frames, the second start bit begins exactly at the end of the first stop bit; total low-to-idle span 2000 cycles.
REQ-031 Overflow: push bytes 0x01..0x06 on six consecutive cycles from idle -> full=1 after the 5th push, 0x06 dropped, and 0x01..0x05 transmitted in order.
REQ-032 Parity: PARITY_EN=1, push 0x07 -> parity bit=1 and frame length 11 bit times; push 0x03 -> parity bit=0.
REQ-033 Reset mid-frame: assert RESETN=0 during the 4th data bit with 2 bytes queued -> TX=1 and empty=1 immediately; after release TX stays high with no pushes.
REQ-034 Minimum divider: CLKS_PER_BIT=2, push 0x55 -> alternating 2-cycle bit cells, frame length 20 cycles.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter, start + 8 data bits LSB first + optional even parity + 1 stop.
// Ports: CLOCK  - clock, all state on rising edge
//        RESETN - asynchronous active-low reset
//        dt/wr  - byte to queue and its push strobe
//        full/empty - FIFO occupancy flags
//        busy   - serializer is sending a frame
//        TX     - registered serial line, idle high
module uart_tx #(
  parameter int CLKS_PER_BIT = 100,
  parameter int FIFO_DEPTH = 4,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic       CLOCK,
  input  logic       RESETN,
  input  logic [7:0] dt,
  input  logic       wr,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       TX
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [19:0] BAUD_MAX = 20'(CLKS_PER_BIT - 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;

  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] cnt_q;
  logic [2:0] state_q, state_d;
  logic [19:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic par_q, par_d, tx_q, tx_d;
  logic push, pop, bit_end;

  assign full = cnt_q == DEPTH;
  assign empty = cnt_q == '0;
  assign busy = state_q != IDLE;
  assign TX = tx_q;
  assign bit_end = baud_q == BAUD_MAX;
  assign push = wr && !full;
  // A new frame is fetched either from idle or exactly at the end of a stop bit, so frames chain with no gap.
  assign pop = !empty && (state_q == IDLE || (state_q == STOP && bit_end));

  always_ff @(posedge CLOCK)
    if (push) mem_q[wptr_q] <= dt;

  always_ff @(posedge CLOCK or negedge RESETN)
    if (!RESETN) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

  always_comb begin
    state_d = state_q;
    baud_d = (state_q == IDLE || bit_end) ? '0 : baud_q + 20'd1;
    bit_d = bit_q;
    sh_d = sh_q;
    par_d = par_q;
    tx_d = tx_q;
    if (pop) begin
      state_d = START;
      sh_d = mem_q[rptr_q];
      par_d = ^mem_q[rptr_q];
      bit_d = '0;
      tx_d = 1'b0;
    end else if (bit_end) begin
      case (state_q)
        START: begin
          state_d = DATA;
          tx_d = sh_q[0];
        end
        DATA:
          if (bit_q == 3'd7) begin
            state_d = PARITY_EN ? PARITY : STOP;
            tx_d = PARITY_EN ? par_q : 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d = sh_q >> 1;
            tx_d = sh_q[1];
          end
        PARITY: begin
          state_d = STOP;
          tx_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
          tx_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESETN)
    if (!RESETN) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      par_q <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      par_q <= par_d;
      tx_q <= tx_d;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three uart_tx configurations checked every cycle against a frame-timeline model
module tb_uart_tx;
  localparam int CPB0 = 100, CPB1 = 4, CPB2 = 2, DEP = 4;
  logic CLOCK = 1'b0, RESETN = 1'b0;
  logic wr_s [3];
  logic [7:0] dt_s [3];
  logic full_o [3], empty_o [3], busy_o [3], tx_o [3];
  int cpb [3] = '{CPB0, CPB1, CPB2};
  bit par [3] = '{1'b0, 1'b1, 1'b0};
  int n_chk = 0, n_fail = 0;
  bit [7:0] mq [3][16];
  bit [7:0] cur [3];
  int mhead [3], mcnt [3], pos [3];
  bit act [3];
  int m_len;
  bit m_fin, m_pop, m_ok;
  logic [9:0] a5;
  logic cap [200];
  bit [7:0] rb;
  int len, span;
  logic pbit;

  always #5 CLOCK = ~CLOCK;

  uart_tx #(.CLKS_PER_BIT(CPB0), .FIFO_DEPTH(DEP), .PARITY_EN(1'b0)) u0 (.CLOCK(CLOCK), .RESETN(RESETN),
    .dt(dt_s[0]), .wr(wr_s[0]), .full(full_o[0]), .empty(empty_o[0]), .busy(busy_o[0]), .TX(tx_o[0]));
  uart_tx #(.CLKS_PER_BIT(CPB1), .FIFO_DEPTH(DEP), .PARITY_EN(1'b1)) u1 (.CLOCK(CLOCK), .RESETN(RESETN),
    .dt(dt_s[1]), .wr(wr_s[1]), .full(full_o[1]), .empty(empty_o[1]), .busy(busy_o[1]), .TX(tx_o[1]));
  uart_tx #(.CLKS_PER_BIT(CPB2), .FIFO_DEPTH(DEP), .PARITY_EN(1'b0)) u2 (.CLOCK(CLOCK), .RESETN(RESETN),
    .dt(dt_s[2]), .wr(wr_s[2]), .full(full_o[2]), .empty(empty_o[2]), .busy(busy_o[2]), .TX(tx_o[2]));

  function automatic logic fbit(input bit [7:0] d, input bit p, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (p && i == 9) return ^d;
    return 1'b1;
  endfunction

  always @(posedge CLOCK or negedge RESETN)
    for (int k = 0; k < 3; k++)
      if (!RESETN) begin
        mcnt[k] = 0;
        mhead[k] = 0;
        act[k] = 1'b0;
        pos[k] = 0;
      end else begin
        m_len = (par[k] ? 11 : 10) * cpb[k];
        m_fin = act[k] && pos[k] == m_len - 1;
        m_pop = (!act[k] || m_fin) && mcnt[k] != 0;
        m_ok = wr_s[k] && mcnt[k] < DEP;
        if (m_pop) begin
          cur[k] = mq[k][mhead[k]];
          mhead[k] = (mhead[k] + 1) % 16;
          mcnt[k]--;
        end
        if (m_ok) begin
          mq[k][(mhead[k] + mcnt[k]) % 16] = dt_s[k];
          mcnt[k]++;
        end
        if (m_pop) begin
          act[k] = 1'b1;
          pos[k] = 0;
        end else if (m_fin) act[k] = 1'b0;
        else if (act[k]) pos[k]++;
      end

  task automatic chk(input string nm, input int k, input logic a, input logic e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s[%0d] got %b expected %b at %0t", nm, k, a, e, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endtask

  task automatic tick;
    @(negedge CLOCK);
    for (int k = 0; k < 3; k++) begin
      chk("tx", k, tx_o[k], act[k] ? fbit(cur[k], par[k], pos[k] / cpb[k]) : 1'b1);
      chk("busy", k, busy_o[k], act[k]);
      chk("empty", k, empty_o[k], mcnt[k] == 0);
      chk("full", k, full_o[k], mcnt[k] == DEP);
    end
  endtask

  task automatic rx_byte(input int k, output bit [7:0] b);
    int t;
    b = '0;
    t = 0;
    while (tx_o[k] !== 1'b0 && t < 3000) begin
      tick;
      t++;
    end
    if (t >= 3000) chk_int("rx_start_timeout", t, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (i == 0 ? cpb[k] + cpb[k] / 2 : cpb[k]) tick;
      b[i] = tx_o[k];
    end
    repeat ((par[k] ? 2 : 1) * cpb[k]) tick;
  endtask

  task automatic frame(input int k, input bit [7:0] d, output int n, output logic p);
    wr_s[k] = 1'b1;
    dt_s[k] = d;
    tick;
    wr_s[k] = 1'b0;
    n = 0;
    p = 1'bx;
    for (int i = 0; i < 200; i++) begin
      tick;
      if (!busy_o[k]) break;
      cap[n] = tx_o[k];
      if (n == 9 * cpb[k] + cpb[k] / 2) p = tx_o[k];
      n++;
    end
  endtask

  task automatic wait_idle(input int bound);
    int t;
    t = 0;
    while ((busy_o[0] || busy_o[1] || busy_o[2] || !empty_o[0] || !empty_o[1] || !empty_o[2]) && t < bound) begin
      tick;
      t++;
    end
    chk_int("idle_timeout", int'(t >= bound), 0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      wr_s[k] = 1'b0;
      dt_s[k] = '0;
    end
    repeat (3) tick;
    chk("rst_tx", 0, tx_o[0], 1'b1);
    chk("rst_empty", 0, empty_o[0], 1'b1);
    chk("rst_busy", 0, busy_o[0], 1'b0);
    chk("rst_full", 0, full_o[0], 1'b0);
    RESETN = 1'b1;
    repeat (5) tick;

    a5 = 10'b1101001010;
    wr_s[0] = 1'b1;
    dt_s[0] = 8'hA5;
    tick;
    wr_s[0] = 1'b0;
    chk("a5_not_started", 0, busy_o[0], 1'b0);
    chk("a5_queued", 0, empty_o[0], 1'b0);
    for (int j = 0; j < 1000; j++) begin
      tick;
      if (j % 100 == 50) chk("a5_cell", j / 100, tx_o[0], a5[j / 100]);
    end
    chk("a5_busy_last", 0, busy_o[0], 1'b1);
    tick;
    chk("a5_idle", 0, busy_o[0], 1'b0);

    wr_s[0] = 1'b1;
    dt_s[0] = 8'h00;
    tick;
    dt_s[0] = 8'hFF;
    tick;
    wr_s[0] = 1'b0;
    span = busy_o[0] ? 1 : 0;
    for (int i = 0; i < 2500 && busy_o[0]; i++) begin
      tick;
      if (busy_o[0]) span++;
    end
    chk_int("b2b_span", span, 2000);

    for (int i = 1; i <= 6; i++) begin
      wr_s[0] = 1'b1;
      dt_s[0] = 8'(i);
      tick;
      if (i == 4) chk("ovf_not_full", 0, full_o[0], 1'b0);
      if (i == 5) chk("ovf_full", 0, full_o[0], 1'b1);
    end
    wr_s[0] = 1'b0;
    chk("ovf_full_after6", 0, full_o[0], 1'b1);
    for (int i = 1; i <= 5; i++) begin
      rx_byte(0, rb);
      chk_int("ovf_order", int'(rb), i);
    end
    wait_idle(3000);
    chk("ovf_drop", 0, empty_o[0], 1'b1);

    frame(1, 8'h07, len, pbit);
    chk_int("par07_len", len, 44);
    chk("par07_bit", 1, pbit, 1'b1);
    frame(1, 8'h03, len, pbit);
    chk_int("par03_len", len, 44);
    chk("par03_bit", 1, pbit, 1'b0);
    frame(2, 8'h55, len, pbit);
    chk_int("min_len", len, 20);
    for (int j = 0; j < 20; j++) chk("min_cell", j, cap[j], logic'((j / 2) % 2));

    for (int c = 0; c < 3000; c++) begin
      wr_s[0] = $urandom_range(0, 299) == 0;
      wr_s[1] = $urandom_range(0, 9) == 0;
      wr_s[2] = $urandom_range(0, 5) == 0;
      for (int k = 0; k < 3; k++) dt_s[k] = 8'($urandom);
      tick;
    end
    for (int k = 0; k < 3; k++) wr_s[k] = 1'b0;
    wait_idle(8000);

    wr_s[0] = 1'b1;
    dt_s[0] = 8'hC3;
    tick;
    dt_s[0] = 8'h3C;
    tick;
    dt_s[0] = 8'h5A;
    tick;
    wr_s[0] = 1'b0;
    repeat (448) tick;
    chk("mid_busy", 0, busy_o[0], 1'b1);
    chk("mid_queued", 0, empty_o[0], 1'b0);
    chk("mid_d3", 0, tx_o[0], 1'b0);
    #2 RESETN = 1'b0;
    #1;
    chk("arst_tx", 0, tx_o[0], 1'b1);
    chk("arst_empty", 0, empty_o[0], 1'b1);
    chk("arst_busy", 0, busy_o[0], 1'b0);
    chk("arst_full", 0, full_o[0], 1'b0);
    tick;
    RESETN = 1'b1;
    repeat (1500) tick;
    chk("post_rst_tx", 0, tx_o[0], 1'b1);
    chk("post_rst_busy", 0, busy_o[0], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
